nf_ahb_tmr: RTL and testbench

- AHB-Lite slave timer/compare peripheral; a fourth slave on the nf_ahb_top slave fabric, alongside GPIO A/B and PWM.
- Decode entry: slave index 3, address match 32'h0003XXXX.
- Provides a free-running or auto-reload counter with prescaler, compare-match and overflow flags, and a level interrupt output for the core.
- Zero-wait-state slave: hready_s is constant 1 and hresp_s is constant OKAY.

---
 rtl/nf_ahb_tmr_pkg.sv | 33 +++
 rtl/nf_ahb_tmr_if.sv | 23 ++
 rtl/nf_tmr_core.sv | 74 +++++++
 rtl/nf_ahb_tmr.sv | 110 +++++++++++
 tb/tb_nf_ahb_tmr.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/nf_ahb_tmr_pkg.sv
// Shared constants for the AHB timer/compare slave: register offsets, CR/SR
// bit positions, AHB HTRANS/HRESP encodings and the fabric decode window.
package nf_ahb_tmr_pkg;

  typedef enum logic [2:0] {
    NF_TMR_CR  = 3'd0,
    NF_TMR_CNT = 3'd1,
    NF_TMR_CMP = 3'd2,
    NF_TMR_PSC = 3'd3,
    NF_TMR_SR  = 3'd4
  } nf_tmr_reg_e;

  localparam int unsigned NF_TMR_CR_EN  = 0;
  localparam int unsigned NF_TMR_CR_AR  = 1;
  localparam int unsigned NF_TMR_CR_MIE = 2;
  localparam int unsigned NF_TMR_CR_OIE = 3;

  localparam int unsigned NF_TMR_SR_MATCH = 0;
  localparam int unsigned NF_TMR_SR_OVF   = 1;

  localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] AHB_HRESP_OKAY = 2'b00;

  // Fabric decode window 32'h0003XXXX, slave index 3.
  localparam logic [31:0] NF_TMR_ADDR_MATCH = 32'h0003_0000;
  localparam logic [31:0] NF_TMR_ADDR_MASK  = 32'hFFFF_0000;
  localparam int unsigned NF_TMR_SLAVE_IDX  = 3;

endpackage

// File: rtl/nf_ahb_tmr_if.sv
// AHB-Lite slave-side bus bundle for the timer peripheral.
interface nf_ahb_tmr_if;
  logic [31:0] haddr_s;
  logic [31:0] hwdata_s;
  logic [31:0] hrdata_s;
  logic        hwrite_s;
  logic [1:0]  htrans_s;
  logic [2:0]  hsize_s;
  logic [2:0]  hburst_s;
  logic [1:0]  hresp_s;
  logic        hready_s;
  logic        hsel_s;

  modport slave (
    input  haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s, hsel_s,
    output hrdata_s, hresp_s, hready_s
  );

  modport master (
    output haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s, hsel_s,
    input  hrdata_s, hresp_s, hready_s
  );
endinterface

// File: rtl/nf_tmr_core.sv
// Timer datapath: prescaler, counter with compare/auto-reload, and the
// MATCH/OVF sticky flags, driven by register values and write strobes.
module nf_tmr_core
  import nf_ahb_tmr_pkg::*;
#(
  parameter int unsigned tmr_w = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ar,
  input  logic [tmr_w-1:0] cmp,
  input  logic [tmr_w-1:0] psc,
  input  logic             cnt_we,
  input  logic [tmr_w-1:0] cnt_wdata,
  input  logic             psc_we,
  input  logic             sr_we,
  input  logic [1:0]       sr_wdata,
  output logic [tmr_w-1:0] cnt,
  output logic             match,
  output logic             ovf
);

  logic [tmr_w-1:0] r_psc_cnt;
  logic [tmr_w-1:0] r_cnt;
  logic             r_match;
  logic             r_ovf;

  logic             w_tick;
  logic             w_hit;
  logic             w_full;
  logic             w_match_set;
  logic             w_ovf_set;
  logic [tmr_w-1:0] w_cnt_nxt;

  always_comb begin
    w_tick      = en & (r_psc_cnt == psc);
    w_hit       = (r_cnt == cmp);
    w_full      = (r_cnt == '1);
    w_match_set = w_tick & w_hit;
    // A match with auto-reload takes precedence over the all-ones wrap.
    w_ovf_set   = w_tick & w_full & ~(w_hit & ar);
    w_cnt_nxt   = (w_hit & ar) ? '0 : r_cnt + tmr_w'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc_cnt <= '0;
      r_cnt     <= '0;
      r_match   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (psc_we)
        r_psc_cnt <= '0;
      else if (w_tick)
        r_psc_cnt <= '0;
      else if (en)
        r_psc_cnt <= r_psc_cnt + tmr_w'(1);

      if (cnt_we)
        r_cnt <= cnt_wdata;
      else if (w_tick)
        r_cnt <= w_cnt_nxt;

      r_match <= w_match_set | (r_match & ~(sr_we & sr_wdata[NF_TMR_SR_MATCH]));
      r_ovf   <= w_ovf_set   | (r_ovf   & ~(sr_we & sr_wdata[NF_TMR_SR_OVF]));
    end
  end

  assign cnt   = r_cnt;
  assign match = r_match;
  assign ovf   = r_ovf;

endmodule

// File: rtl/nf_ahb_tmr.sv
// AHB-Lite zero-wait-state timer/compare slave: address-phase latch,
// data-phase register write decode and read mux around nf_tmr_core.
module nf_ahb_tmr
  import nf_ahb_tmr_pkg::*;
#(
  parameter int unsigned tmr_w = 32
) (
  input  logic         hclk,
  input  logic         hreset,
  nf_ahb_tmr_if.slave  ahb,
  output logic         irq
);

  logic             r_valid;
  logic             r_wr;
  logic [2:0]       r_idx;
  logic [3:0]       r_cr;
  logic [tmr_w-1:0] r_cmp;
  logic [tmr_w-1:0] r_psc;

  logic             w_accept;
  logic             w_we;
  logic             w_we_cr;
  logic             w_we_cnt;
  logic             w_we_cmp;
  logic             w_we_psc;
  logic             w_we_sr;
  logic [tmr_w-1:0] w_wdata;
  logic [tmr_w-1:0] w_cnt;
  logic             w_match;
  logic             w_ovf;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_accept = ahb.hsel_s & ahb.htrans_s[1];
  assign w_wdata  = ahb.hwdata_s[tmr_w-1:0];
  assign w_we     = r_valid & r_wr;
  assign w_we_cr  = w_we & (r_idx == NF_TMR_CR);
  assign w_we_cnt = w_we & (r_idx == NF_TMR_CNT);
  assign w_we_cmp = w_we & (r_idx == NF_TMR_CMP);
  assign w_we_psc = w_we & (r_idx == NF_TMR_PSC);
  assign w_we_sr  = w_we & (r_idx == NF_TMR_SR);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_cr    <= '0;
      r_cmp   <= '0;
      r_psc   <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_wr  <= ahb.hwrite_s;
        r_idx <= ahb.haddr_s[4:2];
      end
      if (w_we_cr)
        r_cr <= ahb.hwdata_s[3:0];
      if (w_we_cmp)
        r_cmp <= w_wdata;
      if (w_we_psc)
        r_psc <= w_wdata;
    end
  end

  nf_tmr_core #(
    .tmr_w (tmr_w)
  ) u_core (
    .clk       (hclk),
    .rst       (hreset),
    .en        (r_cr[NF_TMR_CR_EN]),
    .ar        (r_cr[NF_TMR_CR_AR]),
    .cmp       (r_cmp),
    .psc       (r_psc),
    .cnt_we    (w_we_cnt),
    .cnt_wdata (w_wdata),
    .psc_we    (w_we_psc),
    .sr_we     (w_we_sr),
    .sr_wdata  (ahb.hwdata_s[1:0]),
    .cnt       (w_cnt),
    .match     (w_match),
    .ovf       (w_ovf)
  );

  always_comb begin
    w_rdata = '0;
    if (r_valid && !r_wr) begin
      case (r_idx)
        NF_TMR_CR:  w_rdata[3:0]       = r_cr;
        NF_TMR_CNT: w_rdata[tmr_w-1:0] = w_cnt;
        NF_TMR_CMP: w_rdata[tmr_w-1:0] = r_cmp;
        NF_TMR_PSC: w_rdata[tmr_w-1:0] = r_psc;
        NF_TMR_SR:  w_rdata[1:0]       = {w_ovf, w_match};
        default:    w_rdata            = '0;
      endcase
    end
  end

  assign ahb.hrdata_s = w_rdata;
  assign ahb.hready_s = 1'b1;
  assign ahb.hresp_s  = AHB_HRESP_OKAY;

  assign irq = (w_match & r_cr[NF_TMR_CR_MIE]) | (w_ovf & r_cr[NF_TMR_CR_OIE]);

  // Bus fields this word-only, single-window slave never looks at.
  assign w_unused = ^{ahb.hsize_s, ahb.hburst_s, ahb.haddr_s[31:5],
                      ahb.haddr_s[1:0], ahb.hwdata_s};

endmodule

// File: tb/tb_nf_ahb_tmr.sv
// Randomized + directed bench for nf_ahb_tmr at tmr_w=32 and tmr_w=8, checked
// every cycle against a register-level behavioural model.
module tb_nf_ahb_tmr;

  localparam logic [31:0] BASE = 32'h0003_0000;
  localparam logic [31:0] A_CR  = BASE + 32'h00;
  localparam logic [31:0] A_CNT = BASE + 32'h04;
  localparam logic [31:0] A_CMP = BASE + 32'h08;
  localparam logic [31:0] A_PSC = BASE + 32'h0C;
  localparam logic [31:0] A_SR  = BASE + 32'h10;

  typedef struct {
    logic [31:0] cr, cnt, cmp, psc, pc;
    bit          match, ovf, v, wr;
    int unsigned idx;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_a, irq_b;
  int unsigned n_tot = 0;
  int unsigned n_bad = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  nf_ahb_tmr_if ifa ();
  nf_ahb_tmr_if ifb ();

  nf_ahb_tmr #(.tmr_w(32)) u_a (.hclk(clk), .hreset(rst), .ahb(ifa), .irq(irq_a));
  nf_ahb_tmr #(.tmr_w(8))  u_b (.hclk(clk), .hreset(rst), .ahb(ifb), .irq(irq_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Next register state after one clock, from the programmer's-view rules.
  function automatic mdl_t step(mdl_t s, logic [31:0] m, bit r, bit sel,
                                logic [1:0] tr, bit w, logic [31:0] a, logic [31:0] wd);
    mdl_t n;
    bit tick, mset, oset;
    n = '{default: 0};
    if (r) return n;
    n = s;
    mset = 0;
    oset = 0;
    tick = s.cr[0] && (s.pc == s.psc);
    if (s.cr[0]) n.pc = tick ? 32'd0 : s.pc + 1;
    if (tick) begin
      if (s.cnt == s.cmp) begin
        mset = 1;
        if (s.cr[1]) n.cnt = 0;
        else begin
          if (s.cnt == m) oset = 1;
          n.cnt = (s.cnt + 1) & m;
        end
      end else if (s.cnt == m) begin
        n.cnt = 0;
        oset = 1;
      end else n.cnt = s.cnt + 1;
    end
    if (s.v && s.wr) begin
      case (s.idx)
        0: n.cr = wd & 32'hF;
        1: n.cnt = wd & m;
        2: n.cmp = wd & m;
        3: begin n.psc = wd & m; n.pc = 0; end
        4: begin n.match = s.match && !wd[0]; n.ovf = s.ovf && !wd[1]; end
        default: ;
      endcase
    end
    n.match = n.match | mset;
    n.ovf   = n.ovf | oset;
    n.v     = sel && tr[1];
    n.wr    = w;
    n.idx   = a[4:2];
    return n;
  endfunction

  function automatic logic [31:0] rdata(mdl_t s);
    if (!s.v || s.wr) return 32'd0;
    case (s.idx)
      0: return s.cr;
      1: return s.cnt;
      2: return s.cmp;
      3: return s.psc;
      4: return {30'd0, s.ovf, s.match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic irq_of(mdl_t s);
    return (s.match && s.cr[2]) || (s.ovf && s.cr[3]);
  endfunction

  // One bus cycle: drive, check at negedge, advance model at posedge.
  task automatic cyc(input bit r, input bit sel, input logic [1:0] tr, input bit w,
                     input logic [31:0] a, input logic [31:0] wd);
    rst = r;
    ifa.hsel_s = sel; ifa.htrans_s = tr; ifa.hwrite_s = w; ifa.haddr_s = a; ifa.hwdata_s = wd;
    ifb.hsel_s = sel; ifb.htrans_s = tr; ifb.hwrite_s = w; ifb.haddr_s = a; ifb.hwdata_s = wd;
    @(negedge clk);
    chk("a_hrdata", ifa.hrdata_s, rdata(ma));
    chk("a_irq", {31'd0, irq_a}, {31'd0, irq_of(ma)});
    chk("a_hready", {31'd0, ifa.hready_s}, 32'd1);
    chk("a_hresp", {30'd0, ifa.hresp_s}, 32'd0);
    chk("b_hrdata", ifb.hrdata_s, rdata(mb));
    chk("b_irq", {31'd0, irq_b}, {31'd0, irq_of(mb)});
    chk("b_hready", {31'd0, ifb.hready_s}, 32'd1);
    chk("b_hresp", {30'd0, ifb.hresp_s}, 32'd0);
    @(posedge clk);
    ma = step(ma, 32'hFFFF_FFFF, r, sel, tr, w, a, wd);
    mb = step(mb, 32'h0000_00FF, r, sel, tr, w, a, wd);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 2'b00, 0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 1, 2'b10, 1, a, 32'd0);
    cyc(0, 0, 2'b00, 0, 32'd0, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(0, 1, 2'b10, 0, a, 32'd0);
    cyc(0, 0, 2'b00, 0, 32'd0, 32'd0);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    ifa.hsize_s = 3'b010; ifa.hburst_s = 3'b000;
    ifb.hsize_s = 3'b010; ifb.hburst_s = 3'b000;
    ifa.hsel_s = 0; ifa.htrans_s = 0; ifa.hwrite_s = 0; ifa.haddr_s = 0; ifa.hwdata_s = 0;
    ifb.hsel_s = 0; ifb.htrans_s = 0; ifb.hwrite_s = 0; ifb.haddr_s = 0; ifb.hwdata_s = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 2'b00, 0, 32'd0, 32'd0);

    // Reset state: all five registers read zero.
    rd(A_CR); rd(A_CNT); rd(A_CMP); rd(A_PSC); rd(A_SR);

    // Auto-reload at CMP=5, tick every cycle.
    wr(A_PSC, 0); wr(A_CMP, 5); wr(A_CR, 32'h3);
    for (int unsigned i = 0; i < 14; i++) cyc(0, 1, 2'b10, 0, A_CNT, 32'd0);
    rd(A_SR);

    // Prescaled count with match interrupt, then W1C.
    wr(A_CR, 0); wr(A_SR, 3); wr(A_CNT, 0);
    wr(A_CR, 32'h5); wr(A_PSC, 3); wr(A_CMP, 2);
    for (int unsigned i = 0; i < 20; i++) cyc(0, 1, 2'b11, 0, A_CNT, 32'd0);
    wr(A_SR, 1); rd(A_SR); idle(3);

    // Overflow path (wraps at 8 bits in u_b, compare at 0x10 afterwards).
    wr(A_CR, 0); wr(A_PSC, 0); wr(A_CMP, 32'h10); wr(A_CNT, 32'hFE); wr(A_SR, 3);
    wr(A_CR, 32'h9);
    for (int unsigned i = 0; i < 24; i++) cyc(0, 1, 2'b10, 0, A_CNT, 32'd0);
    rd(A_SR);

    // Pipelined write then read of CMP; CNT write coincident with a tick.
    cyc(0, 1, 2'b10, 1, A_CMP, 32'd0);
    cyc(0, 1, 2'b10, 0, A_CMP, 32'hA5);
    cyc(0, 1, 2'b10, 1, A_CNT, 32'd0);
    cyc(0, 1, 2'b10, 0, A_CNT, 32'd7);
    idle(1);

    // Full-width compare at all-ones without auto-reload.
    wr(A_CR, 0); wr(A_CMP, 32'hFFFF_FFFF); wr(A_CNT, 32'hFFFF_FFFE); wr(A_SR, 3);
    wr(A_CR, 32'hD);
    for (int unsigned i = 0; i < 4; i++) cyc(0, 1, 2'b10, 0, A_SR, 32'd0);

    // Ignored transfers: IDLE/BUSY or unselected writes.
    cyc(0, 1, 2'b00, 1, A_CMP, 32'd0); cyc(0, 0, 2'b10, 1, A_PSC, 32'hFFFF);
    cyc(0, 1, 2'b01, 1, A_CR, 32'hFFFF); cyc(0, 0, 2'b00, 0, 32'd0, 32'hFFFF);
    rd(A_CMP); rd(A_PSC); rd(A_CR);

    // Reset during an open write data phase.
    cyc(0, 1, 2'b10, 1, A_CMP, 32'd0);
    cyc(1, 1, 2'b10, 0, A_CMP, 32'h55);
    idle(1);
    rd(A_CMP); rd(A_CR); rd(A_CNT); rd(A_SR);

    // Random traffic.
    for (int unsigned i = 0; i < 4000; i++) begin
      logic [31:0] a, d;
      bit r;
      a = BASE + ($urandom_range(0, 7) << 2);
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'hFFFF_FFF8 + $urandom_range(0, 7);
        default: d = $urandom_range(0, 20);
      endcase
      if (a[4:2] == 3'd3) d = $urandom_range(0, 3);
      r = ($urandom_range(0, 599) == 0);
      cyc(r, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, a, d);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end

endmodule
